decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/mips_pkg.sv | 38 +++
 rtl/decode_ctrl.sv | 46 ++++
 rtl/decode_stage.sv | 121 ++++++++++++
 tb/tb_decode_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcode/funct constants and decoded-control types for the decode stage.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  // R-type functs that write the long (hi/lo) result pair
  localparam logic [5:0] FN_LONG_FIRST = 6'h18;
  localparam logic [5:0] FN_LONG_LAST  = 6'h1B;

  typedef enum logic [1:0] {
    IMM_SEXT,
    IMM_ZEXT,
    IMM_LUI
  } imm_sel_e;

  typedef struct packed {
    logic mem_write;
    logic alu_src;
    logic alu_reg_write;
    logic mem_reg_write;
    logic long_write;
    logic branch;
    logic illegal;
  } ctrl_t;

  function automatic logic is_long_funct(input logic [5:0] funct);
    return (funct >= FN_LONG_FIRST) && (funct <= FN_LONG_LAST);
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode table: control flags and immediate-extension select.
module decode_ctrl
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output imm_sel_e   imm_sel
);

  always_comb begin
    ctrl    = '0;
    imm_sel = IMM_SEXT;
    case (op)
      OP_R: begin
        if (is_long_funct(funct)) ctrl.long_write    = 1'b1;
        else                      ctrl.alu_reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_src       = 1'b1;
        ctrl.mem_reg_write = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: ctrl.branch = 1'b1;
      OP_ADDI: begin
        ctrl.alu_src       = 1'b1;
        ctrl.alu_reg_write = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.alu_src       = 1'b1;
        ctrl.alu_reg_write = 1'b1;
        imm_sel            = IMM_ZEXT;
      end
      OP_LUI: begin
        ctrl.alu_src       = 1'b1;
        ctrl.alu_reg_write = 1'b1;
        imm_sel            = IMM_LUI;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: load-use interlock, valid/ready handshake, registered bundle.
module decode_stage
  import mips_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 12,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_inst,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  input  logic               ex_load_valid,
  input  logic [4:0]         ex_load_rt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               mem_write,
  output logic               alu_src,
  output logic               alu_reg_write,
  output logic               mem_reg_write,
  output logic               long_write,
  output logic               branch,
  output logic               illegal,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [XLEN-1:0]    imm,
  output logic [ALUOP_W-1:0] aluop,
  output logic [XLEN-1:0]    pc,
  output logic [CNT_W-1:0]   stall_cnt
);

  function automatic logic [XLEN-1:0] ext_imm(input imm_sel_e sel, input logic [15:0] raw);
    logic [XLEN-1:0] r;
    r = '0;
    case (sel)
      IMM_ZEXT: r[15:0]  = raw;
      IMM_LUI:  r[31:16] = raw;
      default:  r = {{(XLEN-16){raw[15]}}, raw};
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Stage p0: combinational decode of the offered instruction
  logic [5:0]      op_p0;
  logic [4:0]      rs_p0, rt_p0;
  ctrl_t           ctrl_p0;
  imm_sel_e        imm_sel_p0;
  logic            reads_rs_p0, reads_rt_p0, hazard_p0, fire_p0;

  assign op_p0 = in_inst[31:26];
  assign rs_p0 = in_inst[25:21];
  assign rt_p0 = in_inst[20:16];

  decode_ctrl u_ctrl (
    .op      (op_p0),
    .funct   (in_inst[5:0]),
    .ctrl    (ctrl_p0),
    .imm_sel (imm_sel_p0)
  );

  assign reads_rs_p0 = (op_p0 != OP_LUI);
  assign reads_rt_p0 = (op_p0 == OP_R) || (op_p0 == OP_SW) || (op_p0 == OP_BEQ);
  assign hazard_p0   = in_valid && ex_load_valid && (ex_load_rt != 5'd0) &&
                       ((reads_rs_p0 && (ex_load_rt == rs_p0)) ||
                        (reads_rt_p0 && (ex_load_rt == rt_p0)));

  logic  vld_p1;
  ctrl_t ctrl_p1;

  assign in_ready = !rst && (!vld_p1 || out_ready) && !hazard_p0 && !flush;
  assign fire_p0  = in_valid && in_ready;

  // Stage p1: registered bundle toward execute
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      ctrl_p1   <= '0;
      rs        <= '0;
      rt        <= '0;
      rd        <= '0;
      imm       <= '0;
      aluop     <= '0;
      pc        <= '0;
      stall_cnt <= '0;
    end else begin
      if (hazard_p0) stall_cnt <= sat_inc(stall_cnt);
      if (flush) begin
        vld_p1 <= 1'b0;
      end else if (fire_p0) begin
        vld_p1  <= 1'b1;
        ctrl_p1 <= ctrl_p0;
        rs      <= rs_p0;
        rt      <= rt_p0;
        rd      <= in_inst[15:11];
        imm     <= ext_imm(imm_sel_p0, in_inst[15:0]);
        aluop   <= in_inst[ALUOP_W-1:0];
        pc      <= in_pc;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid     = vld_p1;
  assign mem_write     = ctrl_p1.mem_write;
  assign alu_src       = ctrl_p1.alu_src;
  assign alu_reg_write = ctrl_p1.alu_reg_write;
  assign mem_reg_write = ctrl_p1.mem_reg_write;
  assign long_write    = ctrl_p1.long_write;
  assign branch        = ctrl_p1.branch;
  assign illegal       = ctrl_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic vs a behavioural model.
module tb_decode_stage;

  localparam int XLEN    = 32;
  localparam int ALUOP_W = 12;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, in_valid, in_ready, flush, ex_load_valid, out_valid, out_ready;
  logic [31:0]        in_inst;
  logic [XLEN-1:0]    in_pc;
  logic [4:0]         ex_load_rt;
  logic               mem_write, alu_src, alu_reg_write, mem_reg_write, long_write, branch, illegal;
  logic [4:0]         rs, rt, rd;
  logic [XLEN-1:0]    imm, pc;
  logic [ALUOP_W-1:0] aluop;
  logic [CNT_W-1:0]   stall_cnt;

  decode_stage #(.XLEN(XLEN), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .ex_load_valid(ex_load_valid), .ex_load_rt(ex_load_rt),
    .out_valid(out_valid), .out_ready(out_ready), .mem_write(mem_write), .alu_src(alu_src),
    .alu_reg_write(alu_reg_write), .mem_reg_write(mem_reg_write), .long_write(long_write),
    .branch(branch), .illegal(illegal), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .aluop(aluop), .pc(pc), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [6:0]  flags; // mem_write, alu_src, alu_reg_write, mem_reg_write, long_write, branch, illegal
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [11:0] aluop;
    logic [31:0] pc;
  } bundle_t;

  bundle_t exp_b;
  logic    exp_valid;
  int      exp_cnt;
  int      vectors = 0;
  int      miscompares = 0;

  function automatic bundle_t ref_decode(input logic [31:0] inst, input logic [31:0] a);
    bundle_t b;
    int unsigned op, fn, raw;
    op  = inst[31:26];
    fn  = inst[5:0];
    raw = inst[15:0];
    b.flags = 7'b0;
    case (op)
      'h00:                  b.flags = (fn >= 'h18 && fn <= 'h1B) ? 7'b0000100 : 7'b0010000;
      'h23:                  b.flags = 7'b0101000;
      'h2B:                  b.flags = 7'b1100000;
      'h04:                  b.flags = 7'b0000010;
      'h08, 'h0C, 'h0D, 'h0E, 'h0F: b.flags = 7'b0110000;
      default:               b.flags = 7'b0000001;
    endcase
    if (op == 'h0C || op == 'h0D || op == 'h0E) b.imm = raw;
    else if (op == 'h0F)                        b.imm = raw * 65536;
    else                                        b.imm = (raw >= 32768) ? raw - 65536 : raw;
    b.rs    = inst[25:21];
    b.rt    = inst[20:16];
    b.rd    = inst[15:11];
    b.aluop = inst[11:0];
    b.pc    = a;
    return b;
  endfunction

  function automatic logic ref_hazard(input logic v, input logic [31:0] inst,
                                      input logic lv, input logic [4:0] lrt);
    int unsigned op;
    logic reads_rs, reads_rt;
    op = inst[31:26];
    if (!v || !lv || lrt == 0) return 1'b0;
    reads_rs = (op != 'h0F);
    reads_rt = (op == 'h00 || op == 'h2B || op == 'h04);
    return (reads_rs && lrt == inst[25:21]) || (reads_rt && lrt == inst[20:16]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] inst, input logic [31:0] a,
                       input logic fl, input logic lv, input logic [4:0] lrt, input logic ordy);
    rst = r; in_valid = v; in_inst = inst; in_pc = a; flush = fl;
    ex_load_valid = lv; ex_load_rt = lrt; out_ready = ordy;
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, exp_valid);
    chk("flags", {mem_write, alu_src, alu_reg_write, mem_reg_write, long_write, branch, illegal}, exp_b.flags);
    chk("rs_rt_rd", {rs, rt, rd}, {exp_b.rs, exp_b.rt, exp_b.rd});
    chk("imm", imm, exp_b.imm);
    chk("aluop", aluop, exp_b.aluop);
    chk("pc", pc, exp_b.pc);
    chk("stall_cnt", stall_cnt, exp_cnt);
  endtask

  // One clock: check in_ready mid-cycle, advance the model at the edge, check outputs after it.
  task automatic cycle();
    logic haz, rdy, fire_m;
    #1;
    haz    = ref_hazard(in_valid, in_inst, ex_load_valid, ex_load_rt);
    rdy    = !rst && (!exp_valid || out_ready) && !haz && !flush;
    chk("in_ready", in_ready, rdy);
    fire_m = in_valid && rdy;
    @(posedge clk);
    if (rst) begin
      exp_valid = 1'b0;
      exp_b     = ref_decode(32'h0, 32'h0);
      exp_b.flags = 7'b0;
      exp_cnt   = 0;
    end else begin
      if (haz && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
      if (flush)             exp_valid = 1'b0;
      else if (fire_m) begin exp_valid = 1'b1; exp_b = ref_decode(in_inst, in_pc); end
      else if (out_ready)    exp_valid = 1'b0;
    end
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] ops [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3F};
    exp_valid = 1'b0;
    exp_cnt   = 0;
    exp_b     = ref_decode(32'h0, 32'h0);

    // reset
    drive(1, 1, 32'h8C430004, 32'h10, 0, 0, 0, 1);
    cycle();
    cycle();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_pc", pc, 32'h0);

    // LW accepted, then ORI / ADDI / LUI back to back
    drive(0, 1, 32'h8C430004, 32'h100, 0, 0, 0, 1);
    cycle();
    chk("lw_valid", out_valid, 1'b1);
    chk("lw_flags", {alu_src, mem_reg_write, mem_write, alu_reg_write}, 4'b1100);
    chk("lw_imm", imm, 32'h00000004);
    chk("lw_rs_rt", {rs, rt}, {5'd2, 5'd3});
    drive(0, 1, 32'h3442FFFF, 32'h104, 0, 0, 0, 1);
    cycle();
    chk("ori_imm", imm, 32'h0000FFFF);
    drive(0, 1, 32'h2042FFFF, 32'h108, 0, 0, 0, 1);
    cycle();
    chk("addi_imm", imm, 32'hFFFFFFFF);
    drive(0, 1, 32'h3C021234, 32'h10C, 0, 0, 0, 1);
    cycle();
    chk("lui_imm", imm, 32'h12340000);
    chk("b2b_valid", out_valid, 1'b1);

    // load-use hazard for two cycles, then run on to saturation
    drive(0, 1, 32'h00631020, 32'h110, 0, 1, 5'd3, 1);
    cycle();
    cycle();
    chk("haz_cnt2", stall_cnt, 4'd2);
    chk("haz_bubble", out_valid, 1'b0);
    for (int i = 0; i < 16; i++) cycle();
    chk("haz_sat", stall_cnt, 4'hF);
    drive(0, 1, 32'h00631020, 32'h110, 0, 0, 5'd3, 1);
    cycle();
    chk("haz_release", out_valid, 1'b1);
    chk("haz_pc", pc, 32'h110);

    // backpressure: accept, then hold for 3 cycles, then drain
    drive(0, 1, 32'h20420001, 32'h200, 0, 0, 0, 1);
    cycle();
    drive(0, 1, 32'h20430002, 32'h204, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_pc", pc, 32'h200);
      chk("hold_valid", out_valid, 1'b1);
    end
    drive(0, 0, 32'h0, 32'h0, 0, 0, 0, 1);
    cycle();
    chk("drain_valid", out_valid, 1'b0);

    // flush while a bundle is held and a new one is offered
    drive(0, 1, 32'h20420005, 32'h300, 0, 0, 0, 1);
    cycle();
    drive(0, 1, 32'h3842000F, 32'h304, 1, 0, 0, 1);
    cycle();
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_pc", pc, 32'h300);
    drive(0, 0, 32'h0, 32'h0, 0, 0, 0, 1);
    cycle();
    chk("flush_dropped", out_valid, 1'b0);

    // illegal opcode
    drive(0, 1, 32'hFC000000, 32'h400, 0, 0, 0, 1);
    cycle();
    chk("illegal_flags", {mem_write, alu_src, alu_reg_write, mem_reg_write, long_write, branch, illegal}, 7'b0000001);

    // reset mid-stream
    drive(1, 1, 32'h8C430004, 32'h500, 0, 1, 5'd2, 1);
    cycle();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_imm", imm, 32'h0);
    chk("midrst_cnt", stall_cnt, 4'd0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic [31:0] inst;
      inst = {ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      if (inst[31:26] == 6'h00 && $urandom_range(0, 1) == 1) inst[5:0] = 6'h18 + 6'($urandom_range(0, 3));
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, inst, $urandom,
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
            $urandom_range(0, 2) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
